cbx_param_cfg: RTL and testbench

Parametrised X-channel connection block with integrated, handshaked configuration storage. It replaces fixed-size connection blocks that use decoder-addressed SRAM. It passes left/right channel tracks straight through and drives NUM_PIN grid input pins from MUX_SIZE-input muxes. Configuration is staged in shadow registers and applied atomically on commit. It sits between switch blocks on a horizontal routing channel and is programmed from the fabric configuration controller.

---
 rtl/cbx_cfg_pkg.sv | 25 ++
 rtl/cbx_ipin_mux.sv | 20 ++
 rtl/cbx_param_cfg.sv | 153 +++++++++++++++
 tb/tb_cbx_param_cfg.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbx_cfg_pkg.sv
// Shared types for the parametrised connection block: command opcodes, the
// configuration FSM states and the per-pin {en, sel} configuration word.
package cbx_cfg_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_READ   = 2'd1,
    OP_COMMIT = 2'd2,
    OP_CLEAR  = 2'd3
  } cfg_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } cfg_state_e;

  // Width-templated holder for the configuration word; use cfg_word_c#(W)::word_t.
  virtual class cfg_word_c #(parameter int SEL_W = 1);
    typedef struct packed {
      logic             en;
      logic [SEL_W-1:0] sel;
    } word_t;
  endclass

endpackage

// File: rtl/cbx_ipin_mux.sv
// One grid-pin driver: MUX_SIZE:1 selection gated by an enable. Select codes at
// or above MUX_SIZE drive 0 so a non-power-of-two mux never reads past its inputs.
module cbx_ipin_mux #(
  parameter int MUX_SIZE = 6,
  parameter int SEL_W    = $clog2(MUX_SIZE)
) (
  input  logic [MUX_SIZE-1:0] mux_in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic                mux_out
);

  localparam logic [SEL_W:0] SEL_LIMIT = MUX_SIZE[SEL_W:0];

  always_comb begin
    mux_out = 1'b0;
    if (en && ({1'b0, sel} < SEL_LIMIT)) mux_out = mux_in[sel];
  end

endmodule

// File: rtl/cbx_param_cfg.sv
// X-channel connection block with shadow/active configuration and atomic commit.
// Define CBX_PARAM_CFG_READBACK_EN to enable READ of the active configuration.
module cbx_param_cfg
  import cbx_cfg_pkg::*;
#(
  parameter int CHAN_W     = 9,
  parameter int NUM_PIN    = 11,
  parameter int MUX_SIZE   = 6,
  parameter int TAP_STRIDE = 4,
  parameter int ADDR_W     = $clog2(NUM_PIN),
  parameter int SEL_W      = $clog2(MUX_SIZE)
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [NUM_PIN-1:0]  ipin_out,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_op,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [SEL_W:0]      cfg_wdata,
  output logic                cfg_rvalid,
  output logic [SEL_W:0]      cfg_rdata,
  output logic                cfg_err,
  output cfg_state_e          dbg_state
);

  typedef cfg_word_c#(SEL_W)::word_t cfg_word_t;

  localparam logic [ADDR_W:0]   NUM_PIN_L = NUM_PIN[ADDR_W:0];
  localparam logic [SEL_W:0]    MUX_L     = MUX_SIZE[SEL_W:0];
  localparam logic [ADDR_W-1:0] LAST_PIN  = ADDR_W'(NUM_PIN - 1);

  cfg_state_e        state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              err_q;
  cfg_word_t         shadow_q [NUM_PIN];
  cfg_word_t         active_q [NUM_PIN];
  cfg_word_t         wr_word;
  logic              addr_ok;
  logic              sel_ok;

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;

  // Handshake: a command is taken on the prog_clk edge where cfg_valid && cfg_ready;
  // ready is high only in IDLE, and responses (rvalid/err) are one-cycle strobes.
  assign cfg_ready = (state_q == ST_IDLE);
  assign cfg_err   = err_q;
  assign dbg_state = state_q;

  assign wr_word = cfg_word_t'(cfg_wdata);
  assign addr_ok = ({1'b0, cfg_addr} < NUM_PIN_L);
  assign sel_ok  = ({1'b0, wr_word.sel} < MUX_L);

`ifdef CBX_PARAM_CFG_READBACK_EN
  logic      rvalid_q;
  cfg_word_t rdata_q;
  assign cfg_rvalid = rvalid_q;
  assign cfg_rdata  = rdata_q;
`else
  assign cfg_rvalid = 1'b0;
  assign cfg_rdata  = '0;
`endif

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      err_q     <= 1'b0;
`ifdef CBX_PARAM_CFG_READBACK_EN
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
`endif
      for (int p = 0; p < NUM_PIN; p++) begin
        shadow_q[p] <= '0;
        active_q[p] <= '0;
      end
    end else begin
      err_q <= 1'b0;
`ifdef CBX_PARAM_CFG_READBACK_EN
      rvalid_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            case (cfg_op_e'(cfg_op))
              OP_WRITE: begin
                if (addr_ok && sel_ok) shadow_q[cfg_addr] <= wr_word;
                else                   err_q <= 1'b1;
              end
              OP_READ: begin
`ifdef CBX_PARAM_CFG_READBACK_EN
                if (addr_ok) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= active_q[cfg_addr];
                end else begin
                  err_q <= 1'b1;
                end
`else
                err_q <= 1'b1;
`endif
              end
              OP_COMMIT: begin
                for (int p = 0; p < NUM_PIN; p++) active_q[p] <= shadow_q[p];
              end
              OP_CLEAR: begin
                state_q   <= ST_CLEAR;
                clr_cnt_q <= '0;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        ST_CLEAR: begin
          // One pin per cycle; both copies go together so a sweep never exposes stale shadow.
          shadow_q[clr_cnt_q] <= '0;
          active_q[clr_cnt_q] <= '0;
          if (clr_cnt_q == LAST_PIN) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Tap pair j of pin p sits on track (p + j*TAP_STRIDE) mod CHAN_W: left then right.
  for (genvar p = 0; p < NUM_PIN; p++) begin : g_pin
    logic [MUX_SIZE-1:0] taps;
    for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_tap
      localparam int TRK = (p + j * TAP_STRIDE) % CHAN_W;
      assign taps[2*j]   = chanx_left_in[TRK];
      assign taps[2*j+1] = chanx_right_in[TRK];
    end
    cbx_ipin_mux #(
      .MUX_SIZE (MUX_SIZE),
      .SEL_W    (SEL_W)
    ) u_mux (
      .mux_in  (taps),
      .sel     (active_q[p].sel),
      .en      (active_q[p].en),
      .mux_out (ipin_out[p])
    );
  end

endmodule

// File: tb/tb_cbx_param_cfg.sv
// Self-checking bench for cbx_param_cfg: vector table, hand sequences for
// CLEAR/reset corners, and randomized commands against a behavioural model.
module tb_cbx_param_cfg;
  import cbx_cfg_pkg::*;

  localparam int CHAN_W     = 9;
  localparam int NUM_PIN    = 11;
  localparam int MUX_SIZE   = 6;
  localparam int TAP_STRIDE = 4;
  localparam int ADDR_W     = 4;
  localparam int SEL_W      = 3;
  localparam int W          = SEL_W + 1;
`ifdef CBX_PARAM_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic               prog_clk = 1'b0;
  logic               pReset_n;
  logic [CHAN_W-1:0]  chanx_left_in, chanx_right_in, chanx_left_out, chanx_right_out;
  logic [NUM_PIN-1:0] ipin_out;
  logic               cfg_valid, cfg_ready, cfg_rvalid, cfg_err;
  logic [1:0]         cfg_op;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [W-1:0]       cfg_wdata, cfg_rdata;
  cfg_state_e         dbg_state;

  cbx_param_cfg #(
    .CHAN_W(CHAN_W), .NUM_PIN(NUM_PIN), .MUX_SIZE(MUX_SIZE),
    .TAP_STRIDE(TAP_STRIDE), .ADDR_W(ADDR_W), .SEL_W(SEL_W)
  ) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n),
    .chanx_left_in(chanx_left_in), .chanx_right_in(chanx_right_in),
    .chanx_left_out(chanx_left_out), .chanx_right_out(chanx_right_out),
    .ipin_out(ipin_out), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_op(cfg_op), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 prog_clk = ~prog_clk;

  // ---------------- model & scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  int           sh_en [NUM_PIN], sh_sel [NUM_PIN];
  int           ac_en [NUM_PIN], ac_sel [NUM_PIN];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_rd;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NUM_PIN; p++) begin
      sh_en[p] = 0; sh_sel[p] = 0; ac_en[p] = 0; ac_sel[p] = 0;
    end
    exp_q.delete();
    last_rd = '0;
  endtask

  // Pin value from the tap rule: pair j = sel/2 on track (p + j*stride) mod CHAN_W,
  // even sel picks the left track, odd sel the right.
  function automatic logic [NUM_PIN-1:0] ref_ipin();
    logic [NUM_PIN-1:0] r;
    r = '0;
    for (int p = 0; p < NUM_PIN; p++) begin
      if (ac_en[p] != 0) begin
        int t;
        t = (p + (ac_sel[p] / 2) * TAP_STRIDE) % CHAN_W;
        r[p] = (ac_sel[p] % 2 == 1) ? chanx_right_in[t] : chanx_left_in[t];
      end
    end
    return r;
  endfunction

  task automatic check_static(input string tag);
    check({tag, "_ipin"}, 32'(ipin_out), 32'(ref_ipin()));
    check({tag, "_lout"}, 32'(chanx_left_out), 32'(chanx_right_in));
    check({tag, "_rout"}, 32'(chanx_right_out), 32'(chanx_left_in));
  endtask

  // ---------------- driver tasks (all start and end on a negedge) ----------------
  task automatic rand_chan();
    chanx_left_in  = CHAN_W'($urandom_range(0, (1 << CHAN_W) - 1));
    chanx_right_in = CHAN_W'($urandom_range(0, (1 << CHAN_W) - 1));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cfg_ready && n < 32) begin
      @(negedge prog_clk);
      n++;
    end
    if (!cfg_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout got=0 exp=1 at %0t", $time);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [W-1:0] wdata, output logic got_err);
    bit exp_err;
    bit acc;
    exp_err = 1'b0;
    wait_ready();
    cfg_op = op; cfg_addr = addr; cfg_wdata = wdata; cfg_valid = 1'b1;
    acc = cfg_ready;
    @(posedge prog_clk);
    if (acc) begin
      case (op)
        2'd0: begin
          if (addr < NUM_PIN && wdata[SEL_W-1:0] < MUX_SIZE) begin
            sh_en[addr]  = int'(wdata[SEL_W]);
            sh_sel[addr] = int'(wdata[SEL_W-1:0]);
          end else exp_err = 1'b1;
        end
        2'd1: begin
          if (RB && addr < NUM_PIN) exp_q.push_back({ac_en[addr] != 0, SEL_W'(ac_sel[addr])});
          else exp_err = 1'b1;
        end
        2'd2: begin
          for (int p = 0; p < NUM_PIN; p++) begin
            ac_en[p] = sh_en[p]; ac_sel[p] = sh_sel[p];
          end
        end
        default: ;
      endcase
    end
    @(negedge prog_clk);
    cfg_valid = 1'b0;
    check("cmd_err", 32'(cfg_err), 32'(exp_err));
    if (exp_q.size() > 0) begin
      check("rvalid", 32'(cfg_rvalid), 32'd1);
      last_rd = exp_q.pop_front();
      check("rdata", 32'(cfg_rdata), 32'(last_rd));
    end else begin
      check("rvalid_idle", 32'(cfg_rvalid), 32'd0);
      check("rdata_hold", 32'(cfg_rdata), 32'(last_rd));
    end
    check_static("cmd");
    got_err = cfg_err;
  endtask

  task automatic reset_now(input string tag);
    cfg_valid = 1'b0;
    pReset_n  = 1'b0;
    #1;
    model_reset();
    check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_rvalid"}, 32'(cfg_rvalid), 32'd0);
    check({tag, "_rdata"}, 32'(cfg_rdata), 32'd0);
    check({tag, "_err"}, 32'(cfg_err), 32'd0);
    check({tag, "_ipin"}, 32'(ipin_out), 32'd0);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);
  endtask

  // CLEAR: ready low for NUM_PIN cycles, pin k zeroed on the (k+1)th edge after acceptance.
  task automatic do_clear(input bit noisy, input int abort_at);
    wait_ready();
    cfg_op = 2'd3; cfg_addr = ADDR_W'($urandom_range(0, 15)); cfg_valid = 1'b1;
    @(posedge prog_clk);
    @(negedge prog_clk);
    for (int k = 0; k < NUM_PIN; k++) begin
      if (k == abort_at) begin
        reset_now("abort");
        return;
      end
      check("clr_ready", 32'(cfg_ready), 32'd0);
      if (noisy) begin
        cfg_op    = 2'($urandom_range(0, 2));
        cfg_addr  = ADDR_W'($urandom_range(0, NUM_PIN - 1));
        cfg_wdata = {1'b1, SEL_W'($urandom_range(0, MUX_SIZE - 1))};
        cfg_valid = 1'b1;
      end else cfg_valid = 1'b0;
      rand_chan();
      @(posedge prog_clk);
      sh_en[k] = 0; sh_sel[k] = 0; ac_en[k] = 0; ac_sel[k] = 0;
      @(negedge prog_clk);
      check("clr_err", 32'(cfg_err), 32'd0);
      check("clr_rvalid", 32'(cfg_rvalid), 32'd0);
      check_static("clr");
    end
    cfg_valid = 1'b0;
    check("clr_done_ready", 32'(cfg_ready), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      wdata;
    logic              exp_err;
    logic [W-1:0]      exp_rd;
  } vec_t;
  vec_t vecs [14];

  logic e;

  initial begin
    cfg_valid = 1'b0; cfg_op = 2'd0; cfg_addr = '0; cfg_wdata = '0;
    chanx_left_in = '0; chanx_right_in = '0;
    pReset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge prog_clk);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_ipin", 32'(ipin_out), 32'd0);
    check("rst_rvalid", 32'(cfg_rvalid), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    // Pass-through and the uncommitted/committed pin 0 sequence.
    chanx_left_in = 9'h1A5; chanx_right_in = 9'h0;
    #1;
    check("pt_right_out", 32'(chanx_right_out), 32'h1A5);
    check("pt_ipin", 32'(ipin_out), 32'd0);
    @(negedge prog_clk);
    do_cmd(2'd0, 4'd0, 4'hB, e);
    chanx_right_in = 9'h010;
    #1 check("nocommit_ipin0", 32'(ipin_out[0]), 32'd0);
    do_cmd(2'd2, 4'd0, 4'h0, e);
    check("commit_ipin0_hi", 32'(ipin_out[0]), 32'd1);
    chanx_right_in = 9'h1EF;
    #1 check("commit_ipin0_lo", 32'(ipin_out[0]), 32'd0);
    @(negedge prog_clk);

    reset_now("rst2");
    vecs[0]  = '{2'd0, 4'd0,  4'hB, 1'b0, 4'h0};
    vecs[1]  = '{2'd0, 4'd11, 4'h9, 1'b1, 4'h0};
    vecs[2]  = '{2'd0, 4'd2,  4'hE, 1'b1, 4'h0};
    vecs[3]  = '{2'd0, 4'd10, 4'hD, 1'b0, 4'h0};
    vecs[4]  = '{2'd0, 4'd15, 4'h8, 1'b1, 4'h0};
    vecs[5]  = '{2'd0, 4'd3,  4'hF, 1'b1, 4'h0};
    vecs[6]  = '{2'd2, 4'd0,  4'h0, 1'b0, 4'h0};
    vecs[7]  = '{2'd1, 4'd0,  4'h0, !RB,  4'hB};
    vecs[8]  = '{2'd1, 4'd12, 4'h0, 1'b1, 4'h0};
    vecs[9]  = '{2'd0, 4'd5,  4'h4, 1'b0, 4'h0};
    vecs[10] = '{2'd1, 4'd10, 4'h0, !RB,  4'hD};
    vecs[11] = '{2'd2, 4'd0,  4'h0, 1'b0, 4'h0};
    vecs[12] = '{2'd1, 4'd5,  4'h0, !RB,  4'h4};
    vecs[13] = '{2'd1, 4'd3,  4'h0, !RB,  4'h0};
    for (int i = 0; i < 14; i++) begin
      rand_chan();
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, e);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      if (vecs[i].op == 2'd1 && !e)
        check($sformatf("vec%0d_rd", i), 32'(cfg_rdata), 32'(vecs[i].exp_rd));
    end

    // Reset while a read response / error strobe is in flight drops it.
    cfg_op = 2'd1; cfg_addr = 4'd0; cfg_valid = 1'b1;
    @(posedge prog_clk);
    #1 pReset_n = 1'b0;
    #1;
    cfg_valid = 1'b0;
    model_reset();
    check("rdabort_rvalid", 32'(cfg_rvalid), 32'd0);
    check("rdabort_err", 32'(cfg_err), 32'd0);
    check("rdabort_ipin", 32'(ipin_out), 32'd0);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    // Populate every pin, commit, stage different shadow, then a quiet and a noisy CLEAR.
    for (int p = 0; p < NUM_PIN; p++)
      do_cmd(2'd0, ADDR_W'(p), {1'b1, SEL_W'($urandom_range(0, MUX_SIZE - 1))}, e);
    do_cmd(2'd2, 4'd0, 4'h0, e);
    do_clear(1'b0, -1);
    do_cmd(2'd2, 4'd0, 4'h0, e);
    check("clr_commit_ipin", 32'(ipin_out), 32'd0);
    for (int p = 0; p < NUM_PIN; p++)
      do_cmd(2'd0, ADDR_W'(p), {1'b1, SEL_W'($urandom_range(0, MUX_SIZE - 1))}, e);
    do_cmd(2'd2, 4'd0, 4'h0, e);
    do_clear(1'b1, -1);
    do_cmd(2'd2, 4'd0, 4'h0, e);

    // Reset at cycle 5 of a CLEAR: pins 5.. still set before reset must end up cleared.
    for (int p = 0; p < NUM_PIN; p++)
      do_cmd(2'd0, ADDR_W'(p), {1'b1, SEL_W'($urandom_range(0, MUX_SIZE - 1))}, e);
    do_cmd(2'd2, 4'd0, 4'h0, e);
    for (int p = 0; p < NUM_PIN; p++)
      do_cmd(2'd0, ADDR_W'(p), {1'b1, SEL_W'($urandom_range(0, MUX_SIZE - 1))}, e);
    do_clear(1'b0, 5);
    check("abort_ready_after", 32'(cfg_ready), 32'd1);
    rand_chan();
    do_cmd(2'd2, 4'd0, 4'h0, e);
    check("abort_commit_ipin", 32'(ipin_out), 32'd0);

    // Randomized command stream.
    for (int i = 0; i < 300; i++) begin
      int r;
      rand_chan();
      r = $urandom_range(0, 99);
      if (r < 50)
        do_cmd(2'd0, ADDR_W'($urandom_range(0, 12)), W'($urandom_range(0, (1 << W) - 1)), e);
      else if (r < 72)
        do_cmd(2'd1, ADDR_W'($urandom_range(0, 12)), '0, e);
      else if (r < 96)
        do_cmd(2'd2, '0, '0, e);
      else
        do_clear(1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
